pkt_beat_assembler: RTL and testbench
=====================================

Name: pkt_beat_assembler

Overview:
- Generalised receive-side packet endpoint for inter-unit links, e.g. Decoder->ROB, which uses 4 beats, and RRU->ROB, which uses 2 beats.
- Accepts a stream of fixed-width beats under valid/ready and frames them into multi-beat messages of parametrised length.
- Buffers complete messages in a small FIFO and presents each message in parallel, together with its extracted ROB index, to the consuming unit.
- Replaces hand-wired per-link beat capture with one reusable block.

Parameters:
- BEAT_WIDTH, 32, bits per beat (packet word).
- BEATS_PER_MSG, 4, beats per message, >=1.
- FIFO_DEPTH, 4, complete messages buffered, >=2, power of two.
- ROB_IDX_WIDTH, 7, width of the ROB index held in the top bits of beat 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_first  in  1  marks beat 0 of a message.
- in_beat  in  BEAT_WIDTH  beat payload.
- out_valid  out  1  FIFO head message valid.
- out_ready  in  1  consumer pops head when out_valid && out_ready.
- out_msg  out  BEATS_PER_MSG*BEAT_WIDTH  beat k at bits [(k+1)*BEAT_WIDTH-1 : k*BEAT_WIDTH].
- out_rob_idx  out  ROB_IDX_WIDTH  equals beat0[BEAT_WIDTH-1 -: ROB_IDX_WIDTH] of the head message.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - Beat counter = 0; FIFO empty; partial assembly discarded.
  - out_valid=0, frame_err=0.
  - out_msg and out_rob_idx = 0.
  - in_ready=1 (FIFO empty).
- Reset asserted mid-message or with a full FIFO clears everything in the same cycle; no message survives.
- Assembly:
  - Beat counter beat_cnt runs 0..BEATS_PER_MSG-1.
  - An accepted beat is written into assembly slot beat_cnt, then beat_cnt increments.
  - The final beat (beat_cnt==BEATS_PER_MSG-1) pushes the assembled message, including the final beat, into the FIFO and wraps beat_cnt to 0.
- Latency:
  - The message is visible at out_valid the cycle after its final beat is accepted.
  - There is no combinational path from in_* to out_*.
- Backpressure:
  - in_ready = (beat_cnt != BEATS_PER_MSG-1) || !fifo_full || (out_valid && out_ready).
  - Non-final beats are never stalled.
  - Push and pop in the same cycle while full is legal; occupancy is unchanged.
- Framing:
  - in_first=1 with beat_cnt!=0: the partial message is discarded, the beat is stored as beat 0 (beat_cnt becomes 1, or the message pushes immediately if BEATS_PER_MSG==1), and frame_err pulses.
  - in_first=0 with beat_cnt==0: the orphan beat is accepted and dropped, beat_cnt stays 0, and frame_err pulses.
  - frame_err is registered and asserts the cycle after the offending beat.
- Output:
  - out_msg and out_rob_idx come from the registered FIFO head.
  - They hold stable while out_valid && !out_ready.
- FIFO:
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Occupancy is $clog2(FIFO_DEPTH)+1 bits.
  - Pop on empty has no effect.

Optional Feature:
- Macro: PKT_ASM_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt, 8 bits, reset 0.
  - Increments on every frame_err pulse and saturates at 255.
  - Adds input err_cnt_clr; err_cnt_clr=1 zeroes the counter and wins over a simultaneous increment.
- Undefined: the err_cnt and err_cnt_clr ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Packet package:
  - Constants PKT_BEAT_WIDTH=32, DEC_TO_ROB_BEATS=4, RRU_TO_ROB_BEATS=2.
  - Typedef PktBeat_T, logic[31:0].
  - Function robIndexOfBeat0() used for the out_rob_idx slice.
- Existing Type package supplies RobIndex_T width, which is the ROB_IDX_WIDTH default.
- One sub-module: pkt_msg_fifo, a parametrised width/depth synchronous FIFO with full/empty and same-cycle push/pop. The framing FSM and counter stay in the top module.

Test Plan:
- Four beats 0xFE00_0001, 0x2, 0x3, 0x4 with in_first on beat 0, out_ready=1:
  - out_valid rises the cycle after beat 3.
  - out_msg = {0x4, 0x3, 0x2, 0xFE000001}.
  - out_rob_idx = 0x7F.
- out_ready=0, stream 5 messages:
  - 4 buffered.
  - in_ready drops only on beat 3 of message 5.
  - out_ready=1 for one cycle: message 5 is accepted in the same cycle and FIFO occupancy stays 4.
- Beats 0xA(first), 0xB, then 0xC(first), 0xD, 0xE, 0xF:
  - frame_err pulses once.
  - Only message {0xF, 0xE, 0xD, 0xC} emerges.
- Idle, then beat 0x55 with in_first=0:
  - Beat accepted and dropped; frame_err pulses; beat_cnt stays 0.
  - A subsequent valid message assembles correctly.
- rst asserted after 2 beats with 2 messages queued:
  - Next cycle out_valid=0, in_ready=1.
  - A fresh message completes normally.
- With PKT_ASM_ERR_CNT_EN: 300 orphan beats give err_cnt=255; err_cnt_clr together with an error gives err_cnt=0.

Source files
------------

// File: rtl/pkt_beat_assembler_pkg.sv
// Shared packet-link types and constants for the beat assembler and its FIFO.
package pkt_beat_assembler_pkg;

    localparam int PKT_BEAT_WIDTH   = 32;
    localparam int DEC_TO_ROB_BEATS = 4;
    localparam int RRU_TO_ROB_BEATS = 2;
    localparam int ROB_INDEX_WIDTH  = 7;

    typedef logic [PKT_BEAT_WIDTH-1:0]  PktBeat_T;
    typedef logic [ROB_INDEX_WIDTH-1:0] RobIndex_T;

    // The ROB index travels in the top bits of beat 0 of every message.
    function automatic RobIndex_T robIndexOfBeat0(input PktBeat_T beat0);
        return beat0[PKT_BEAT_WIDTH-1 -: ROB_INDEX_WIDTH];
    endfunction

endpackage

// File: rtl/pkt_msg_fifo.sv
// Parametrised synchronous message FIFO with same-cycle push/pop.
module pkt_msg_fifo
    import pkt_beat_assembler_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pkt_beat_assembler.sv
// Frames valid/ready beats into multi-beat messages and queues them for the ROB.
// Optional error counter enabled by defining PKT_ASM_ERR_CNT_EN.
module pkt_beat_assembler
    import pkt_beat_assembler_pkg::*;
#(
    parameter int BEAT_WIDTH    = PKT_BEAT_WIDTH,
    parameter int BEATS_PER_MSG = DEC_TO_ROB_BEATS,
    parameter int FIFO_DEPTH    = 4,
    parameter int ROB_IDX_WIDTH = $bits(RobIndex_T)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_first,
    input  logic [BEAT_WIDTH-1:0]               in_beat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BEATS_PER_MSG*BEAT_WIDTH-1:0] out_msg,
    output logic [ROB_IDX_WIDTH-1:0]            out_rob_idx,
    output logic                                frame_err
`ifdef PKT_ASM_ERR_CNT_EN
    ,
    input  logic                                err_cnt_clr,
    output logic [7:0]                          err_cnt
`endif
);

    localparam int MSG_W = BEATS_PER_MSG * BEAT_WIDTH;
    localparam int CNT_W = (BEATS_PER_MSG > 1) ? $clog2(BEATS_PER_MSG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS_PER_MSG - 1);

    logic [CNT_W-1:0]      beat_cnt;
    logic [BEAT_WIDTH-1:0] slot [BEATS_PER_MSG];
    logic [MSG_W-1:0]      push_msg;
    logic [MSG_W-1:0]      head_msg;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  is_last;
    logic                  accept;
    logic                  push;
    logic                  pop;

    assign is_last   = (beat_cnt == LAST);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !is_last || !fifo_full || pop;
    assign accept    = in_valid && in_ready;
    // A first beat only completes a message when messages are a single beat long.
    assign push      = accept && (in_first ? (BEATS_PER_MSG == 1)
                                           : (is_last && (beat_cnt != '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                if (in_first) begin
                    frame_err <= (beat_cnt != '0);
                    beat_cnt  <= (BEATS_PER_MSG == 1) ? '0 : CNT_W'(1);
                end else if (beat_cnt == '0) begin
                    frame_err <= 1'b1;
                end else if (is_last) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (in_first) slot[0] <= in_beat;
            else if (beat_cnt != '0) slot[beat_cnt] <= in_beat;
        end
    end

    // The final beat bypasses the slots so the message pushes on its acceptance cycle.
    always_comb begin
        push_msg = '0;
        for (int k = 0; k < BEATS_PER_MSG - 1; k++)
            push_msg[k*BEAT_WIDTH +: BEAT_WIDTH] = slot[k];
        push_msg[(BEATS_PER_MSG-1)*BEAT_WIDTH +: BEAT_WIDTH] = in_beat;
    end

    pkt_msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_msg),
        .rdata (head_msg),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_msg = head_msg;

    generate
        if (BEAT_WIDTH == PKT_BEAT_WIDTH && ROB_IDX_WIDTH == $bits(RobIndex_T)) begin : g_pkg_idx
            assign out_rob_idx = robIndexOfBeat0(head_msg[BEAT_WIDTH-1:0]);
        end else begin : g_raw_idx
            assign out_rob_idx = head_msg[BEAT_WIDTH-1 -: ROB_IDX_WIDTH];
        end
    endgenerate

`ifdef PKT_ASM_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (frame_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_beat_assembler.sv
// Testbench for pkt_beat_assembler against a queue-based framing model.
module tb_pkt_beat_assembler;

    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 4;
    localparam int R = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_first = 1'b0;
    logic [W-1:0]   in_beat = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] out_msg;
    logic [R-1:0]   out_rob_idx;
    logic           frame_err;
`ifdef PKT_ASM_ERR_CNT_EN
    logic           err_cnt_clr = 1'b0;
    logic [7:0]     err_cnt;
    int             e_ecnt = 0;
`endif

    logic [W-1:0]   part[$];
    logic [N*W-1:0] mq[$];
    logic           e_err = 1'b0;
    int             total = 0;
    int             passed = 0;

    always #5 clk = ~clk;

    pkt_beat_assembler #(
        .BEAT_WIDTH    (W),
        .BEATS_PER_MSG (N),
        .FIFO_DEPTH    (D),
        .ROB_IDX_WIDTH (R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .in_beat     (in_beat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_msg     (out_msg),
        .out_rob_idx (out_rob_idx),
        .frame_err   (frame_err)
`ifdef PKT_ASM_ERR_CNT_EN
        ,
        .err_cnt_clr (err_cnt_clr),
        .err_cnt     (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic f, input logic [W-1:0] b, input logic ordy);
        logic           e_rdy;
        logic           acc;
        logic           pp;
        logic [N*W-1:0] em;
        logic [N*W-1:0] m;
        in_valid  = v;
        in_first  = f;
        in_beat   = b;
        out_ready = ordy;
        #1;
        e_rdy = (part.size() != N - 1) || (mq.size() < D) || (mq.size() > 0 && ordy);
        em    = (mq.size() > 0) ? mq[0] : '0;
        chk("in_ready", N*W'(in_ready), N*W'(e_rdy));
        chk("out_valid", N*W'(out_valid), N*W'(mq.size() > 0));
        chk("out_msg", out_msg, em);
        chk("out_rob_idx", N*W'(out_rob_idx), N*W'(em[W-1 -: R]));
        chk("frame_err", N*W'(frame_err), N*W'(e_err));
`ifdef PKT_ASM_ERR_CNT_EN
        chk("err_cnt", N*W'(err_cnt), N*W'(e_ecnt));
`endif
        acc = v && e_rdy;
        pp  = ordy && (mq.size() > 0);
        @(posedge clk);
`ifdef PKT_ASM_ERR_CNT_EN
        if (err_cnt_clr) e_ecnt = 0;
        else if (e_err && e_ecnt < 255) e_ecnt++;
`endif
        e_err = 1'b0;
        if (pp) void'(mq.pop_front());
        if (acc) begin
            if (f) begin
                e_err = (part.size() != 0);
                part.delete();
                part.push_back(b);
            end else if (part.size() == 0) begin
                e_err = 1'b1;
            end else begin
                part.push_back(b);
            end
            if (part.size() == N) begin
                m = '0;
                for (int k = 0; k < N; k++) m[k*W +: W] = part[k];
                mq.push_back(m);
                part.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        part.delete();
        mq.delete();
        e_err = 1'b0;
`ifdef PKT_ASM_ERR_CNT_EN
        e_ecnt = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", N*W'(out_valid), '0);
        chk("rst_in_ready", N*W'(in_ready), N*W'(1));
        chk("rst_frame_err", N*W'(frame_err), '0);
        chk("rst_out_msg", out_msg, '0);
        chk("rst_rob_idx", N*W'(out_rob_idx), '0);
    endtask

    task automatic send_msg(input logic [W-1:0] base, input logic ordy);
        for (int k = 0; k < N; k++) step(1'b1, k == 0, base + W'(k), ordy);
    endtask

    initial begin
        logic v;
        logic f;
        repeat (2) @(negedge clk);
        do_reset();

        // Single message, ROB index in top bits of beat 0
        step(1'b1, 1'b1, 32'hFE00_0001, 1'b1);
        step(1'b1, 1'b0, 32'h2, 1'b1);
        step(1'b1, 1'b0, 32'h3, 1'b1);
        step(1'b1, 1'b0, 32'h4, 1'b1);
        chk("first_msg_valid", N*W'(out_valid), N*W'(1));
        chk("first_msg", out_msg, 128'h00000004_00000003_00000002_FE000001);
        chk("first_rob_idx", N*W'(out_rob_idx), N*W'(7'h7F));
        step(1'b0, 1'b0, '0, 1'b1);

        // Fill FIFO with out_ready low; the fifth final beat stalls
        for (int i = 0; i < 4; i++) send_msg(32'h100 * (i + 1), 1'b0);
        for (int k = 0; k < N - 1; k++) step(1'b1, k == 0, 32'h500 + k, 1'b0);
        in_valid = 1'b1; in_first = 1'b0; in_beat = 32'h503; out_ready = 1'b0;
        #1;
        chk("stall_in_ready", N*W'(in_ready), '0);
        @(negedge clk);
        step(1'b1, 1'b0, 32'h503, 1'b0);
        step(1'b1, 1'b0, 32'h503, 1'b1);
        chk("full_after_pushpop", N*W'(mq.size()), N*W'(D));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("drained", N*W'(out_valid), '0);

        // Restart mid-message
        step(1'b1, 1'b1, 32'hA, 1'b1);
        step(1'b1, 1'b0, 32'hB, 1'b1);
        step(1'b1, 1'b1, 32'hC, 1'b1);
        chk("restart_err", N*W'(frame_err), N*W'(1));
        step(1'b1, 1'b0, 32'hD, 1'b1);
        step(1'b1, 1'b0, 32'hE, 1'b1);
        step(1'b1, 1'b0, 32'hF, 1'b1);
        chk("restart_msg", out_msg, 128'h0000000F_0000000E_0000000D_0000000C);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("restart_single", N*W'(out_valid), '0);

        // Orphan beat from idle, then a clean message
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 32'h55, 1'b1);
        chk("orphan_err", N*W'(frame_err), N*W'(1));
        send_msg(32'h0600_0000, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset with two messages queued and a partial message
        send_msg(32'h700, 1'b0);
        send_msg(32'h800, 1'b0);
        step(1'b1, 1'b1, 32'h900, 1'b0);
        step(1'b1, 1'b0, 32'h901, 1'b0);
        do_reset();
        send_msg(32'hAA00_0000, 1'b0);
        chk("post_rst_msg", out_msg, 128'hAA000003_AA000002_AA000001_AA000000);
        step(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = (part.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
            step(v, f, $urandom, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

`ifdef PKT_ASM_ERR_CNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 32'h55, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("err_cnt_sat", N*W'(err_cnt), N*W'(255));
        step(1'b1, 1'b0, 32'h55, 1'b1);
        err_cnt_clr = 1'b1;
        step(1'b0, 1'b0, '0, 1'b1);
        err_cnt_clr = 1'b0;
        chk("err_cnt_clr", N*W'(err_cnt), '0);
        step(1'b0, 1'b0, '0, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
